multicycle_control: RTL and testbench

- Sequencing FSM for the multicycle MIPS datapath: one shared memory, instruction register, single ALU reused across cycles.
- Replaces the single-cycle control path; keeps the same op/funct/zero inputs and the same 4-bit alu_control encoding.
- Emits Moore-decoded datapath enables and mux selects per state.
- Stretches memory states until the memory signals mem_ready.

---
 rtl/multicycle_control.sv | 162 ++++++++++++++++
 tb/tb_multicycle_control.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS control sequencer: Moore-decoded datapath enables per state,
// with memory states stretched until mem_ready (when USE_MEM_READY is set).
module multicycle_control #(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [3:0] alu_control,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_reg;
    state_t state_next;
    logic   rdy;
    logic   pc_write;
    logic   branch;

    assign rdy   = mem_ready | ~USE_MEM_READY;
    assign state = state_reg;
    // Branch resolves in the same cycle the ALU compares A and B.
    assign pc_en = pc_write | (branch & zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = FETCH;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        alu_control = 4'b0010;
        pc_write    = 1'b0;
        branch      = 1'b0;

        case (state_reg)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                ir_write   = rdy;
                pc_write   = rdy;
                state_next = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                // Branch target is computed speculatively while op is decoded.
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JUMP;
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                iord       = 1'b1;
                mem_read   = 1'b1;
                state_next = rdy ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                state_next = rdy ? FETCH : MEMWRITE;
            end
            EXECUTE: begin
                alu_src_a  = 1'b1;
                state_next = ALUWB;
                case (funct)
                    6'b100010: alu_control = 4'b0110;
                    6'b100100: alu_control = 4'b0000;
                    6'b100101: alu_control = 4'b0001;
                    6'b101010: alu_control = 4'b0111;
                    default:   alu_control = 4'b0010;
                endcase
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = 4'b0110;
                branch      = 1'b1;
                pc_src      = 2'b01;
            end
            ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: expected per-cycle state/outputs are queued per
// instruction and popped against the DUT each cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [3:0] alu_control;
    logic [3:0] state;

    int total_checks = 0;
    int bad_checks   = 0;

    typedef struct {
        logic [3:0]  st;
        logic [16:0] outs;
    } exp_t;

    exp_t exp_q[$];

    multicycle_control #(.USE_MEM_READY(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .iord        (iord),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .mem_to_reg  (mem_to_reg),
        .reg_dst     (reg_dst),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_checks++;
        if (got !== want) begin
            bad_checks++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Output table for a state, packed as
    // {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
    //  alu_src_a, alu_src_b[1:0], pc_src[1:0], alu_control[3:0]}.
    function automatic logic [16:0] exp_outs(input logic [3:0] st, input logic [5:0] fn,
                                             input logic z, input logic rdy);
        logic pe, io, mr, mw, iw, m2r, rd, rw, sa;
        logic [1:0] sb, ps;
        logic [3:0] ac;
        {pe, io, mr, mw, iw, m2r, rd, rw, sa} = '0;
        sb = 2'b00;
        ps = 2'b00;
        ac = 4'b0010;
        case (st)
            4'd0:  begin mr = 1'b1; sb = 2'b01; iw = rdy; pe = rdy; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1'b1; sb = 2'b10; end
            4'd3:  begin io = 1'b1; mr = 1'b1; end
            4'd4:  begin m2r = 1'b1; rw = 1'b1; end
            4'd5:  begin io = 1'b1; mw = 1'b1; end
            4'd6: begin
                sa = 1'b1;
                ac = (fn == 6'b100010) ? 4'b0110 :
                     (fn == 6'b100100) ? 4'b0000 :
                     (fn == 6'b100101) ? 4'b0001 :
                     (fn == 6'b101010) ? 4'b0111 : 4'b0010;
            end
            4'd7:  begin rd = 1'b1; rw = 1'b1; end
            4'd8:  begin sa = 1'b1; ac = 4'b0110; ps = 2'b01; pe = z; end
            4'd9:  begin sa = 1'b1; sb = 2'b10; end
            4'd10: rw = 1'b1;
            4'd11: begin ps = 2'b10; pe = 1'b1; end
            default: ;
        endcase
        return {pe, io, mr, mw, iw, m2r, rd, rw, sa, sb, ps, ac};
    endfunction

    // seq: expected states, one nibble per cycle, first cycle in the most
    // significant used nibble. rdy/rst: per-cycle inputs, first cycle in bit n-1.
    task automatic run_instr(input string name, input logic [5:0] op_v, input logic [5:0] fn_v,
                             input logic z_v, input int n, input logic [47:0] seq,
                             input logic [15:0] rdy, input logic [15:0] rst);
        exp_t e;
        exp_t got;
        int   bad_before;
        bad_before = bad_checks;
        for (int i = 0; i < n; i++) begin
            e.st   = seq[4*(n-1-i) +: 4];
            e.outs = exp_outs(e.st, fn_v, z_v, rdy[n-1-i]);
            exp_q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            op        = op_v;
            funct     = fn_v;
            zero      = z_v;
            mem_ready = rdy[n-1-i];
            reset     = rst[n-1-i];
            #1;
            got = exp_q.pop_front();
            check($sformatf("%s.c%0d.state", name, i), {28'd0, state}, {28'd0, got.st});
            check($sformatf("%s.c%0d.outs", name, i),
                  {15'd0, pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                   reg_write, alu_src_a, alu_src_b, pc_src, alu_control},
                  {15'd0, got.outs});
            @(posedge clk);
            #1;
        end
        $display("txn %-12s op=%b funct=%b zero=%0d cycles=%0d errors=%0d",
                 name, op_v, fn_v, z_v, n, bad_checks - bad_before);
    endtask

    initial begin
        reset     = 1'b1;
        op        = 6'd0;
        funct     = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;

        run_instr("lw",        6'b100011, 6'b000000, 1'b0, 5, 48'h01234,   16'b11111,   16'b0);
        run_instr("slt",       6'b000000, 6'b101010, 1'b0, 4, 48'h0167,    16'b1111,    16'b0);
        run_instr("sub",       6'b000000, 6'b100010, 1'b0, 4, 48'h0167,    16'b1111,    16'b0);
        run_instr("or",        6'b000000, 6'b100101, 1'b0, 4, 48'h0167,    16'b1111,    16'b0);
        run_instr("and",       6'b000000, 6'b100100, 1'b0, 4, 48'h0167,    16'b1111,    16'b0);
        run_instr("badfunct",  6'b000000, 6'b111111, 1'b0, 4, 48'h0167,    16'b1111,    16'b0);
        run_instr("beq_taken", 6'b000100, 6'b000000, 1'b1, 3, 48'h018,     16'b111,     16'b0);
        run_instr("beq_not",   6'b000100, 6'b000000, 1'b0, 3, 48'h018,     16'b111,     16'b0);
        run_instr("sw_wait3",  6'b101011, 6'b000000, 1'b0, 7, 48'h0125555, 16'b1110001, 16'b0);
        run_instr("fetchwait", 6'b001000, 6'b000000, 1'b0, 6, 48'h00019A,  16'b001111,  16'b0);
        run_instr("illegal",   6'b111111, 6'b000000, 1'b0, 2, 48'h01,      16'b11,      16'b0);
        run_instr("lw_reset",  6'b100011, 6'b000000, 1'b0, 5, 48'h01233,   16'b11100,   16'b00001);
        run_instr("jump",      6'b000010, 6'b000000, 1'b0, 3, 48'h01B,     16'b111,     16'b0);
        run_instr("lw_wait",   6'b100011, 6'b000000, 1'b1, 7, 48'h0123334, 16'b1110011, 16'b0);
        run_instr("after",     6'b111111, 6'b000000, 1'b0, 1, 48'h0,       16'b1,       16'b0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
